// File: rtl/utf8_pkg.sv
// utf8_pkg: shared state type, byte-class boundaries and continuation
// bounds used by the UTF-8 decoder and its lead-byte classifier.
package utf8_pkg;

    typedef enum logic {
        IDLE,
        CONT
    } state_e;

    // Lead byte classes
    localparam logic [7:0] ASCII_MAX = 8'h7F;
    localparam logic [7:0] LEAD2_MIN = 8'hC2;
    localparam logic [7:0] LEAD2_MAX = 8'hDF;
    localparam logic [7:0] LEAD3_MIN = 8'hE0;
    localparam logic [7:0] LEAD3_MAX = 8'hEF;
    localparam logic [7:0] LEAD4_MIN = 8'hF0;
    localparam logic [7:0] LEAD4_MAX = 8'hF4;

    // Leads whose first continuation byte has a narrowed range
    localparam logic [7:0] LEAD_E0 = 8'hE0;
    localparam logic [7:0] LEAD_ED = 8'hED;
    localparam logic [7:0] LEAD_F0 = 8'hF0;
    localparam logic [7:0] LEAD_F4 = 8'hF4;

    // Generic continuation range and the narrowed first-continuation bounds
    localparam logic [7:0] CONT_MIN    = 8'h80;
    localparam logic [7:0] CONT_MAX    = 8'hBF;
    localparam logic [7:0] E0_CONT_MIN = 8'hA0;
    localparam logic [7:0] ED_CONT_MAX = 8'h9F;
    localparam logic [7:0] F0_CONT_MIN = 8'h90;
    localparam logic [7:0] F4_CONT_MAX = 8'h8F;

    // U+FFFD, emitted for each invalid maximal subpart when replacement is built in
    localparam logic [20:0] DEFAULT_REPLACEMENT = 21'h00FFFD;

endpackage

// File: rtl/utf8_lead_classifier.sv
// utf8_lead_classifier: purely combinational decode of a byte seen in IDLE.
// Reports whether it can start a sequence, how many continuation bytes
// follow, the payload bits it carries and the legal range of the first
// continuation byte (narrowed to exclude overlongs, surrogates and >U+10FFFF).
module utf8_lead_classifier
    import utf8_pkg::*;
(
    input  logic [7:0]  lead_i,
    output logic        valid_o,
    output logic [1:0]  need_o,
    output logic [20:0] payload_o,
    output logic [7:0]  contMin_o,
    output logic [7:0]  contMax_o
);

    // Range-match the byte against the lead classes; unmatched bytes are invalid
    always_comb begin
        valid_o   = 1'b0;
        need_o    = 2'd0;
        payload_o = '0;
        contMin_o = CONT_MIN;
        contMax_o = CONT_MAX;
        if (lead_i <= ASCII_MAX) begin
            valid_o   = 1'b1;
            payload_o = {13'd0, lead_i};
        end else if (lead_i >= LEAD2_MIN && lead_i <= LEAD2_MAX) begin
            valid_o   = 1'b1;
            need_o    = 2'd1;
            payload_o = {16'd0, lead_i[4:0]};
        end else if (lead_i >= LEAD3_MIN && lead_i <= LEAD3_MAX) begin
            valid_o   = 1'b1;
            need_o    = 2'd2;
            payload_o = {17'd0, lead_i[3:0]};
            if (lead_i == LEAD_E0) contMin_o = E0_CONT_MIN;
            if (lead_i == LEAD_ED) contMax_o = ED_CONT_MAX;
        end else if (lead_i >= LEAD4_MIN && lead_i <= LEAD4_MAX) begin
            valid_o   = 1'b1;
            need_o    = 2'd3;
            payload_o = {18'd0, lead_i[2:0]};
            if (lead_i == LEAD_F0) contMin_o = F0_CONT_MIN;
            if (lead_i == LEAD_F4) contMax_o = F4_CONT_MAX;
        end
    end

endmodule

// File: rtl/utf8_decoder.sv
// utf8_decoder: reassembles 1-4 byte UTF-8 sequences from the receive FIFO
// into 21-bit code points with available/ready handshakes on both sides.
// Optional feature macro: UTF8_DECODER_REPLACEMENT_EN -- when defined, each
// invalid maximal subpart emits REPLACEMENT and a bad byte that interrupts a
// sequence is held in a replay register and decoded as a lead one cycle later.
// When undefined, invalid input is silently dropped and a bad byte is
// re-decoded as a lead in the same cycle.
module utf8_decoder
    import utf8_pkg::*;
`ifdef UTF8_DECODER_REPLACEMENT_EN
#(
    parameter logic [20:0] REPLACEMENT = DEFAULT_REPLACEMENT
)
`endif
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_data_available,
    output logic        in_ready,
    output logic [20:0] out_data,
    output logic        out_data_available,
    input  logic        out_ready
);

    state_e      state_q, state_d;
    logic [1:0]  need_q, need_d;
    logic [14:0] acc_q, acc_d;
    logic [7:0]  contMin_q, contMin_d;
    logic [7:0]  contMax_q, contMax_d;
    logic [20:0] outData_q, outData_d;
    logic        outValid_q, outValid_d;

    logic        replayPending;
    logic        outFree;
    logic        byteAccept;
    logic        decodeLead;
    logic [7:0]  leadByte;
    logic [20:0] accNext;

    logic        leadValid;
    logic [1:0]  leadNeed;
    logic [20:0] leadPayload;
    logic [7:0]  leadContMin;
    logic [7:0]  leadContMax;

`ifdef UTF8_DECODER_REPLACEMENT_EN
    logic        replayPending_q, replayPending_d;
    logic [7:0]  replayByte_q, replayByte_d;

    assign replayPending = replayPending_q;
    assign leadByte      = replayPending_q ? replayByte_q : in_data;
`else
    assign replayPending = 1'b0;
    assign leadByte      = in_data;
`endif

    assign outFree            = !outValid_q || out_ready;
    assign in_ready           = !replayPending && outFree;
    assign byteAccept         = in_data_available && in_ready;
    assign accNext            = {acc_q, in_data[5:0]};
    assign out_data           = outData_q;
    assign out_data_available = outValid_q;

    utf8_lead_classifier u_classifier (
        .lead_i    (leadByte),
        .valid_o   (leadValid),
        .need_o    (leadNeed),
        .payload_o (leadPayload),
        .contMin_o (leadContMin),
        .contMax_o (leadContMax)
    );

    // Next-state decode: continuation handling first, then any byte that must be treated as a lead
    always_comb begin
        state_d    = state_q;
        need_d     = need_q;
        acc_d      = acc_q;
        contMin_d  = contMin_q;
        contMax_d  = contMax_q;
        outData_d  = outData_q;
        outValid_d = outValid_q && !out_ready;
        decodeLead = 1'b0;
`ifdef UTF8_DECODER_REPLACEMENT_EN
        replayPending_d = replayPending_q;
        replayByte_d    = replayByte_q;
        if (replayPending_q && outFree) begin
            replayPending_d = 1'b0;
            decodeLead      = 1'b1;
        end
`endif
        if (byteAccept) begin
            if (state_q == IDLE) begin
                decodeLead = 1'b1;
            end else if (in_data >= contMin_q && in_data <= contMax_q) begin
                acc_d     = accNext[14:0];
                contMin_d = CONT_MIN;
                contMax_d = CONT_MAX;
                if (need_q == 2'd1) begin
                    outData_d  = accNext;
                    outValid_d = 1'b1;
                    state_d    = IDLE;
                    need_d     = 2'd0;
                end else begin
                    need_d = need_q - 2'd1;
                end
            end else begin
                state_d   = IDLE;
                need_d    = 2'd0;
                contMin_d = CONT_MIN;
                contMax_d = CONT_MAX;
`ifdef UTF8_DECODER_REPLACEMENT_EN
                outData_d       = REPLACEMENT;
                outValid_d      = 1'b1;
                replayPending_d = 1'b1;
                replayByte_d    = in_data;
`else
                decodeLead = 1'b1;
`endif
            end
        end
        if (decodeLead) begin
            if (!leadValid) begin
                state_d = IDLE;
                need_d  = 2'd0;
`ifdef UTF8_DECODER_REPLACEMENT_EN
                outData_d  = REPLACEMENT;
                outValid_d = 1'b1;
`endif
            end else if (leadNeed == 2'd0) begin
                state_d    = IDLE;
                need_d     = 2'd0;
                outData_d  = leadPayload;
                outValid_d = 1'b1;
            end else begin
                state_d   = CONT;
                need_d    = leadNeed;
                acc_d     = leadPayload[14:0];
                contMin_d = leadContMin;
                contMax_d = leadContMax;
            end
        end
    end

    // State and output registers; reset discards any partial sequence silently
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            need_q     <= 2'd0;
            acc_q      <= '0;
            contMin_q  <= CONT_MIN;
            contMax_q  <= CONT_MAX;
            outData_q  <= '0;
            outValid_q <= 1'b0;
`ifdef UTF8_DECODER_REPLACEMENT_EN
            replayPending_q <= 1'b0;
            replayByte_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            need_q     <= need_d;
            acc_q      <= acc_d;
            contMin_q  <= contMin_d;
            contMax_q  <= contMax_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
`ifdef UTF8_DECODER_REPLACEMENT_EN
            replayPending_q <= replayPending_d;
            replayByte_q    <= replayByte_d;
`endif
        end
    end

endmodule

// File: tb/tb_utf8_decoder.sv
// tb_utf8_decoder: self-checking bench for utf8_decoder. Works with or
// without UTF8_DECODER_REPLACEMENT_EN; the expected streams follow the macro.
`timescale 1ns/1ps
module tb_utf8_decoder;
    import utf8_pkg::*;

    localparam logic [20:0] REPL = DEFAULT_REPLACEMENT;
`ifdef UTF8_DECODER_REPLACEMENT_EN
    localparam bit REPL_ON = 1'b1;
`else
    localparam bit REPL_ON = 1'b0;
`endif
    localparam int CYCLE_BUDGET = 5000;

    logic        clk;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_data_available;
    logic        in_ready;
    logic [20:0] out_data;
    logic        out_data_available;
    logic        out_ready;

    int testsRun;
    int testsFailed;

    typedef struct {
        string            name;
        logic [0:3][7:0]  bytes;
        int               nBytes;
        logic [0:3][20:0] exp;
        int               nExp;
    } vec_t;

    vec_t vecs[$];

    utf8_decoder dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .in_data            (in_data),
        .in_data_available  (in_data_available),
        .in_ready           (in_ready),
        .out_data           (out_data),
        .out_data_available (out_data_available),
        .out_ready          (out_ready)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard stop in case something hangs
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input string name, input logic [31:0] b, input int nb, input logic [83:0] e, input int ne);
        vec_t v;
        v.name   = name;
        v.bytes  = b;
        v.nBytes = nb;
        v.exp    = e;
        v.nExp   = ne;
        vecs.push_back(v);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n           = 1'b0;
        in_data_available = 1'b0;
        out_ready         = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    // Reference decoder: maximal-subpart UTF-8 decoding in plain arithmetic
    function automatic void modelDecode(input logic [7:0] bq[$], output logic [20:0] eq[$]);
        int i;
        int n;
        eq = {};
        i  = 0;
        n  = bq.size();
        while (i < n) begin
            int b0, len, lo, hi, cp, j, bv;
            bit bad, cut;
            b0 = int'(bq[i]);
            lo = 128; hi = 191; len = 0; cp = 0; bad = 0; cut = 0;
            if (b0 < 128) begin len = 1; cp = b0; end
            else if (b0 >= 194 && b0 <= 223) begin len = 2; cp = b0 - 192; end
            else if (b0 >= 224 && b0 <= 239) begin
                len = 3; cp = b0 - 224;
                if (b0 == 224) lo = 160;
                if (b0 == 237) hi = 159;
            end else if (b0 >= 240 && b0 <= 244) begin
                len = 4; cp = b0 - 240;
                if (b0 == 240) lo = 144;
                if (b0 == 244) hi = 143;
            end
            if (len == 0) begin
                if (REPL_ON) eq.push_back(REPL);
                i++;
            end else begin
                j = 1;
                while (j < len && !bad && !cut) begin
                    if (i + j >= n) cut = 1;
                    else begin
                        bv = int'(bq[i + j]);
                        if (bv < lo || bv > hi) bad = 1;
                        else begin
                            cp = cp * 64 + (bv - 128);
                            lo = 128; hi = 191;
                            j++;
                        end
                    end
                end
                if (cut) i = n;
                else if (bad) begin
                    if (REPL_ON) eq.push_back(REPL);
                    i += j;
                end else begin
                    eq.push_back(21'(cp));
                    i += len;
                end
            end
        end
    endfunction

    function automatic void encodeCp(input int cp, output logic [7:0] enc[$]);
        enc = {};
        if (cp < 'h80) enc.push_back(8'(cp));
        else if (cp < 'h800) begin
            enc.push_back(8'(192 + cp / 64));
            enc.push_back(8'(128 + cp % 64));
        end else if (cp < 'h10000) begin
            enc.push_back(8'(224 + cp / 4096));
            enc.push_back(8'(128 + (cp / 64) % 64));
            enc.push_back(8'(128 + cp % 64));
        end else begin
            enc.push_back(8'(240 + cp / 262144));
            enc.push_back(8'(128 + (cp / 4096) % 64));
            enc.push_back(8'(128 + (cp / 64) % 64));
            enc.push_back(8'(128 + cp % 64));
        end
    endfunction

    task automatic buildRandomStream(output logic [7:0] bq[$]);
        int items;
        logic [7:0] edgeLeads[4];
        edgeLeads[0] = 8'hE0; edgeLeads[1] = 8'hED; edgeLeads[2] = 8'hF0; edgeLeads[3] = 8'hF4;
        bq = {};
        items = $urandom_range(20, 40);
        for (int k = 0; k < items; k++) begin
            int kind;
            int cp;
            logic [7:0] enc[$];
            kind = $urandom_range(0, 9);
            cp   = 0;
            if (kind == 0) bq.push_back(8'($urandom_range(0, 255)));
            else if (kind == 1) begin
                bq.push_back(edgeLeads[$urandom_range(0, 3)]);
                bq.push_back(8'($urandom_range(128, 191)));
            end else begin
                if (kind <= 3) cp = $urandom_range(0, 'h7F);
                else if (kind <= 5) cp = $urandom_range('h80, 'h7FF);
                else if (kind <= 7) begin
                    cp = $urandom_range('h800, 'hFFFF);
                    if (cp >= 'hD800 && cp <= 'hDFFF) cp -= 'h800;
                end else cp = $urandom_range('h10000, 'h10FFFF);
                encodeCp(cp, enc);
                if (enc.size() > 1 && $urandom_range(0, 7) == 0) void'(enc.pop_back());
                foreach (enc[m]) bq.push_back(enc[m]);
            end
        end
    endtask

    // Streams bytes into the DUT and collects every accepted code point
    task automatic applyStimulus(input logic [7:0] bq[$], input bit jitter,
                                 output logic [20:0] got[$], output int stalls);
        int idx;
        int idle;
        int cyc;
        bit holdValid;
        logic [20:0] holdData;
        idx = 0; idle = 0; cyc = 0; holdValid = 0; holdData = '0; stalls = 0;
        got = {};
        while ((idx < bq.size() || idle < 6) && cyc < CYCLE_BUDGET) begin
            @(negedge clk);
            if (holdValid)
                checkOutput("held output", {10'd0, out_data_available, out_data}, {10'd0, 1'b1, holdData});
            if (idx < bq.size() && (!jitter || $urandom_range(0, 3) != 0)) begin
                in_data_available = 1'b1;
                in_data           = bq[idx];
            end else begin
                in_data_available = 1'b0;
                in_data           = 8'($urandom);
            end
            out_ready = jitter ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (in_data_available && !in_ready) stalls++;
            if (out_data_available && out_ready) got.push_back(out_data);
            holdValid = out_data_available && !out_ready;
            holdData  = out_data;
            if (in_data_available && in_ready) idx++;
            if (idx >= bq.size()) idle = out_data_available ? 0 : idle + 1;
            cyc++;
        end
        in_data_available = 1'b0;
        out_ready         = 1'b1;
        if (cyc >= CYCLE_BUDGET) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL stimulus budget: got %0d cycles, expected fewer than %0d", cyc, CYCLE_BUDGET);
        end
    endtask

    task automatic compareStreams(input string name, input logic [20:0] got[$], input logic [20:0] exp[$]);
        checkOutput({name, " count"}, got.size(), exp.size());
        for (int k = 0; k < exp.size(); k++)
            checkOutput({name, " data"}, (k < got.size()) ? {11'd0, got[k]} : 32'hDEADBEEF, {11'd0, exp[k]});
    endtask

    initial begin
        logic [7:0]  bq[$];
        logic [20:0] got[$];
        logic [20:0] exp[$];
        int          stalls;

        clk = 1'b0; reset_n = 1'b0; in_data = '0; in_data_available = 1'b0; out_ready = 1'b1;
        testsRun = 0; testsFailed = 0;

        addVec("ascii pair",       32'h41420000, 2, {21'h41, 21'h42, 42'h0}, 2);
        addVec("euro",             32'hE282AC00, 3, {21'h20AC, 63'h0}, 1);
        addVec("emoji",            32'hF09F9880, 4, {21'h1F600, 63'h0}, 1);
        addVec("above max",        32'hF4908080, 4, {4{REPL}}, REPL_ON ? 4 : 0);
        addVec("C3 41",            32'hC3410000, 2,
               REPL_ON ? {REPL, 21'h41, 42'h0} : {21'h41, 63'h0}, REPL_ON ? 2 : 1);
        addVec("surrogate",        32'hEDA08000, 3, {{3{REPL}}, 21'h0}, REPL_ON ? 3 : 0);
        addVec("C0 80",            32'hC0800000, 2, {{2{REPL}}, 42'h0}, REPL_ON ? 2 : 0);
        addVec("min 2-byte",       32'hC2800000, 2, {21'h80, 63'h0}, 1);
        addVec("max scalar",       32'hF48FBFBF, 4, {21'h10FFFF, 63'h0}, 1);
        addVec("min 3-byte",       32'hE0A08000, 3, {21'h800, 63'h0}, 1);
        addVec("below surrogates", 32'hED9FBF00, 3, {21'hD7FF, 63'h0}, 1);
        addVec("overlong E0",      32'hE09F8000, 3, {{3{REPL}}, 21'h0}, REPL_ON ? 3 : 0);
        addVec("F5",               32'hF5000000, 1, {REPL, 63'h0}, REPL_ON ? 1 : 0);
        addVec("min 4-byte",       32'hF0908080, 4, {21'h10000, 63'h0}, 1);

        // Reset values
        doReset();
        checkOutput("reset out_valid", {31'd0, out_data_available}, 32'd0);
        checkOutput("reset out_data", {11'd0, out_data}, 32'd0);
        checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);

        // Table-driven vectors
        foreach (vecs[v]) begin
            bq = {};
            exp = {};
            for (int k = 0; k < vecs[v].nBytes; k++) bq.push_back(vecs[v].bytes[k]);
            for (int k = 0; k < vecs[v].nExp; k++) exp.push_back(vecs[v].exp[k]);
            doReset();
            applyStimulus(bq, 1'b0, got, stalls);
            compareStreams(vecs[v].name, got, exp);
        end

        // One-cycle latency and full throughput for 41 42
        doReset();
        in_data = 8'h41; in_data_available = 1'b1; out_ready = 1'b1;
        #1;
        checkOutput("in_ready for 41", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        checkOutput("41 latency valid", {31'd0, out_data_available}, 32'd1);
        checkOutput("41 latency data", {11'd0, out_data}, 32'h41);
        in_data = 8'h42;
        #1;
        checkOutput("in_ready for 42", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        checkOutput("42 latency valid", {31'd0, out_data_available}, 32'd1);
        checkOutput("42 latency data", {11'd0, out_data}, 32'h42);
        in_data_available = 1'b0;
        @(posedge clk); #1;
        checkOutput("drained valid", {31'd0, out_data_available}, 32'd0);

        // Back-pressure: 41 held while 42 waits, then both released in order
        doReset();
        in_data = 8'h41; in_data_available = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        checkOutput("bp first valid", {31'd0, out_data_available}, 32'd1);
        in_data = 8'h42;
        repeat (3) begin
            #1;
            checkOutput("bp in_ready low", {31'd0, in_ready}, 32'd0);
            checkOutput("bp data held", {11'd0, out_data}, 32'h41);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp release in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("bp release data", {11'd0, out_data}, 32'h41);
        @(posedge clk); #1;
        in_data_available = 1'b0;
        checkOutput("bp second data", {11'd0, out_data}, 32'h42);
        checkOutput("bp second valid", {31'd0, out_data_available}, 32'd1);
        @(posedge clk); #1;
        checkOutput("bp drained", {31'd0, out_data_available}, 32'd0);

        // Error recovery stall count: C3 41 42 back to back
        doReset();
        bq = {8'hC3, 8'h41, 8'h42};
        exp = {};
        if (REPL_ON) exp.push_back(REPL);
        exp.push_back(21'h41);
        exp.push_back(21'h42);
        applyStimulus(bq, 1'b0, got, stalls);
        compareStreams("C3 41 42", got, exp);
        checkOutput("C3 41 42 stalls", stalls, REPL_ON ? 32'd1 : 32'd0);

        bq = {8'h41, 8'h42, 8'h43};
        applyStimulus(bq, 1'b0, got, stalls);
        checkOutput("ascii stalls", stalls, 32'd0);

        // Reset clears a pending output
        doReset();
        in_data = 8'h41; in_data_available = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_data_available = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset clears valid", {31'd0, out_data_available}, 32'd0);
        checkOutput("reset clears data", {11'd0, out_data}, 32'd0);

        // Reset mid-sequence discards the partial E2 82
        doReset();
        bq = {8'hE2, 8'h82};
        applyStimulus(bq, 1'b0, got, stalls);
        checkOutput("partial no output", got.size(), 32'd0);
        doReset();
        bq = {8'h41};
        exp = {21'h41};
        applyStimulus(bq, 1'b0, got, stalls);
        compareStreams("after mid reset", got, exp);

        // Randomized streams with random gaps and back-pressure
        for (int t = 0; t < 25; t++) begin
            buildRandomStream(bq);
            modelDecode(bq, exp);
            doReset();
            applyStimulus(bq, 1'b1, got, stalls);
            compareStreams("random", got, exp);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
